// File: rtl/fetch_queue_superscalar.sv
// Dual-issue fetch PC plus circular instruction queue feeding decode two-wide.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_queue_superscalar #(
  parameter int          DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [63:0]            imem_addr0,
  output logic [63:0]            imem_addr1,
  input  logic [31:0]            imem_instr0,
  input  logic [31:0]            imem_instr1,
  input  logic                   redirect,
  input  logic [63:0]            redirect_pc,
  output logic                   dec_valid0,
  output logic [31:0]            dec_instr0,
  output logic [63:0]            dec_pc0,
  output logic                   dec_valid1,
  output logic [31:0]            dec_instr1,
  output logic [63:0]            dec_pc1,
  input  logic [1:0]             dec_take,
  output logic [$clog2(DEPTH):0] fq_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_redirects
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FETCH_MAX = CW'(DEPTH - 2);

  logic [63:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [63:0]   epc_q   [DEPTH];

  logic          fetch_en;
  logic [1:0]    avail;
  logic [1:0]    take_c;
  logic [AW-1:0] head1, tail1;

  assign head1 = head_q + AW'(1);
  assign tail1 = tail_q + AW'(1);

  // Fetch space is judged on current occupancy only; same-cycle takes do not help.
  always_comb begin
    fetch_en = !redirect && (count_q <= FETCH_MAX);
    avail    = (count_q >= CW'(2)) ? 2'd2 : ((count_q != '0) ? 2'd1 : 2'd0);
    take_c   = (dec_take > avail) ? avail : dec_take;
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d    = {redirect_pc[63:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(take_c);
      count_d = count_q + (fetch_en ? CW'(2) : CW'(0)) - CW'(take_c);
      if (fetch_en) begin
        tail_d = tail_q + AW'(2);
        pc_d   = pc_q + 64'd8;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fetch_en) begin
      instr_q[tail_q] <= imem_instr0;
      epc_q[tail_q]   <= pc_q;
      instr_q[tail1]  <= imem_instr1;
      epc_q[tail1]    <= pc_q + 64'd4;
    end
  end

  assign imem_addr0 = pc_q;
  assign imem_addr1 = pc_q + 64'd4;
  assign dec_valid0 = (count_q != '0);
  assign dec_valid1 = (count_q >= CW'(2));
  assign dec_instr0 = instr_q[head_q];
  assign dec_pc0    = epc_q[head_q];
  assign dec_instr1 = instr_q[head1];
  assign dec_pc1    = epc_q[head1];
  assign fq_count   = count_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q, redir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (!redirect && (count_q > FETCH_MAX)) stall_q <= stall_q + 32'd1;
      if (redirect) redir_q <= redir_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_redirects    = redir_q;
`endif

`ifndef SYNTHESIS
  take_legal_a: assert property (@(posedge clk) disable iff (rst || redirect)
    (dec_take <= avail));
`endif

endmodule

// File: tb/tb_fetch_queue_superscalar.sv
// Randomised and directed bench for fetch_queue_superscalar against a queue-based model.
module tb_fetch_queue_superscalar;

  localparam int          DEPTH = 8;
  localparam logic [63:0] RPC   = 64'h1000;

  logic        clk;
  logic        rst;
  logic [63:0] imem_addr0, imem_addr1;
  logic [31:0] imem_instr0, imem_instr1;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        dec_valid0, dec_valid1;
  logic [31:0] dec_instr0, dec_instr1;
  logic [63:0] dec_pc0, dec_pc1;
  logic [1:0]  dec_take;
  logic [3:0]  fq_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_redirects;
`endif

  int checks   = 0;
  int failures = 0;

  logic [95:0] mq[$];
  logic [63:0] mpc;

  function automatic logic [31:0] imem_f(input logic [63:0] a);
    return {16'hAAAA ^ a[31:16], a[15:0]};
  endfunction

  assign imem_instr0 = imem_f(imem_addr0);
  assign imem_instr1 = imem_f(imem_addr1);

  fetch_queue_superscalar #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_addr0(imem_addr0), .imem_addr1(imem_addr1),
    .imem_instr0(imem_instr0), .imem_instr1(imem_instr1),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid0(dec_valid0), .dec_instr0(dec_instr0), .dec_pc0(dec_pc0),
    .dec_valid1(dec_valid1), .dec_instr1(dec_instr1), .dec_pc1(dec_pc1),
    .dec_take(dec_take), .fq_count(fq_count)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check_eq("count", 96'(fq_count), 96'(mq.size()));
    check_eq("valid0", 96'(dec_valid0), 96'(mq.size() >= 1));
    check_eq("valid1", 96'(dec_valid1), 96'(mq.size() >= 2));
    check_eq("addr0", 96'(imem_addr0), 96'(mpc));
    check_eq("addr1", 96'(imem_addr1), 96'(mpc + 64'd4));
    if (mq.size() >= 1) check_eq("head0", {dec_instr0, dec_pc0}, mq[0]);
    if (mq.size() >= 2) check_eq("head1", {dec_instr1, dec_pc1}, mq[1]);
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic r, input logic rd, input logic [63:0] rpc, input logic [1:0] tk);
    bit fe;
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    dec_take    = tk;
    if (r) begin
      mq.delete();
      mpc = RPC;
    end else if (rd) begin
      mq.delete();
      mpc = {rpc[63:2], 2'b00};
    end else begin
      fe = (mq.size() <= DEPTH - 2);
      for (int i = 0; i < int'(tk) && mq.size() > 0; i++) void'(mq.pop_front());
      if (fe) begin
        mq.push_back({imem_f(mpc), mpc});
        mq.push_back({imem_f(mpc + 64'd4), mpc + 64'd4});
        mpc = mpc + 64'd8;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [63:0] exp_pc;
    logic [63:0] rnd_pc;
    int          mx;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_take = 2'd0;
    mpc = RPC;
    @(negedge clk);

    // Reset and first fetch
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("rst_valid0", 96'(dec_valid0), 96'(0));
    check_eq("rst_count", 96'(fq_count), 96'(0));
    step(0, 0, 0, 0);
    check_eq("first_pc0", 96'(dec_pc0), 96'(64'h1000));
    check_eq("first_pc1", 96'(dec_pc1), 96'(64'h1004));
    check_eq("first_instr0", 96'(dec_instr0), 96'(32'hAAAA1000));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      check_eq("fill_count", 96'(fq_count), 96'((i < 3) ? 4 + 2 * i : 8));
    end
    check_eq("fill_pc_stop", 96'(imem_addr0), 96'(64'h1020));

    // Odd drain: 8 -> 7 -> 6 -> 7, across the pointer wrap
    step(0, 0, 0, 1); check_eq("odd_c7", 96'(fq_count), 96'(7));
    step(0, 0, 0, 1); check_eq("odd_c6", 96'(fq_count), 96'(6));
    step(0, 0, 0, 1); check_eq("odd_c7b", 96'(fq_count), 96'(7));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Full throughput
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    exp_pc = 64'h1000;
    for (int i = 0; i < 8; i++) begin
      check_eq("tp_pc0", 96'(dec_pc0), 96'(exp_pc));
      check_eq("tp_pc1", 96'(dec_pc1), 96'(exp_pc + 64'd4));
      step(0, 0, 0, 2);
      check_eq("tp_count", 96'(fq_count), 96'(2));
      exp_pc = exp_pc + 64'd8;
    end

    // Redirect with simultaneous take
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check_eq("redir_pre_count", 96'(fq_count), 96'(6));
    step(0, 1, 64'h2003, 2);
    check_eq("redir_count", 96'(fq_count), 96'(0));
    check_eq("redir_v1", 96'(dec_valid1), 96'(0));
    step(0, 0, 0, 0);
    check_eq("redir_pc0", 96'(dec_pc0), 96'(64'h2000));

    // PC wrap
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    step(0, 0, 0, 0);
    check_eq("wrap_pc0", 96'(dec_pc0), 96'(64'hFFFF_FFFF_FFFF_FFF8));
    check_eq("wrap_pc1", 96'(dec_pc1), 96'(64'hFFFF_FFFF_FFFF_FFFC));
    step(0, 0, 0, 2);
    check_eq("wrap_pc2", 96'(dec_pc0), 96'(64'h0));
    check_eq("wrap_pc3", 96'(dec_pc1), 96'(64'h4));

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      mx = (mq.size() >= 2) ? 2 : mq.size();
      rnd_pc = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) rnd_pc = {32'hFFFF_FFFF, 16'hFFFF, 16'($urandom_range(65535, 65500))};
      step(($urandom_range(99, 0) == 0), ($urandom_range(19, 0) == 0), rnd_pc,
           2'($urandom_range(mx, 0)));
    end

`ifdef FETCH_PERF_EN
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 64'h3000, 0);
    check_eq("perf_stall", 96'(perf_stall_cycles), 96'(10));
    check_eq("perf_redir", 96'(perf_redirects), 96'(3));
    step(1, 0, 0, 0);
    check_eq("perf_stall_rst", 96'(perf_stall_cycles), 96'(0));
    check_eq("perf_redir_rst", 96'(perf_redirects), 96'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
